// File: rtl/servo_array_ctrl_if.sv
// Target-write handshake between the game controller and the servo array.
interface servo_array_ctrl_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 17
) ();
  logic             tgt_valid;
  logic             tgt_ready;
  logic [CH_W-1:0]  tgt_ch;
  logic [CNT_W-1:0] tgt_pos;
  logic             tgt_err;

  modport master (
    output tgt_valid, tgt_ch, tgt_pos,
    input  tgt_ready, tgt_err
  );

  modport slave (
    input  tgt_valid, tgt_ch, tgt_pos,
    output tgt_ready, tgt_err
  );
endinterface

// File: rtl/servo_array_ctrl.sv
// Multi-channel hobby-servo PWM generator: shared frame counter, per-channel
// jog or target-slew positioning, updated only at frame boundaries.
module servo_array_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 17,
  parameter int FRAME_TICKS = 100,
  parameter int MIN_PULSE   = 7,
  parameter int MAX_PULSE   = 23,
  parameter int HOME_PULSE  = 15,
  parameter int STEP        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       l_ctrl,
  input  logic [NUM_CH-1:0]       r_ctrl,
  input  logic [NUM_CH-1:0]       mode,
  servo_array_ctrl_if.slave       tgt_if,
  output logic [NUM_CH-1:0]       servo,
  output logic                    frame_tick,
  output logic [NUM_CH-1:0]       at_target,
  output logic [NUM_CH*CNT_W-1:0] pos_flat
);

  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] HOME_P   = CNT_W'(HOME_PULSE);
  localparam logic [CNT_W-1:0] STEP_P   = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos      [NUM_CH];
  logic [CNT_W-1:0] tgt      [NUM_CH];
  logic [CNT_W-1:0] pos_next [NUM_CH];
  logic [CNT_W-1:0] tgt_next [NUM_CH];
  logic [CNT_W-1:0] tgt_clamped;
  logic             err_q;
  logic             accept;
  logic             bad_ch;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] room);
    return (room < STEP_P) ? room : STEP_P;
  endfunction

  assign frame_tick    = !rst && en && (cnt == LAST_CNT);
  assign tgt_if.tgt_ready = !rst && !frame_tick;
  assign accept        = tgt_if.tgt_valid && tgt_if.tgt_ready;
  assign bad_ch        = ({1'b0, tgt_if.tgt_ch} >= NUM_CH_L);
  assign tgt_if.tgt_err   = !rst && err_q;

  always_comb begin
    tgt_clamped = tgt_if.tgt_pos;
    if (tgt_if.tgt_pos < MIN_P)
      tgt_clamped = MIN_P;
    else if (tgt_if.tgt_pos > MAX_P)
      tgt_clamped = MAX_P;
  end

  // Saturating steps keep pos inside [MIN, MAX] in jog mode and stop exactly on tgt in target mode.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pos_next[i] = pos[i];
      tgt_next[i] = tgt[i];
      if (mode[i]) begin
        if (pos[i] < tgt[i])
          pos_next[i] = pos[i] + sat_step(tgt[i] - pos[i]);
        else if (pos[i] > tgt[i])
          pos_next[i] = pos[i] - sat_step(pos[i] - tgt[i]);
      end else begin
        if (l_ctrl[i] && !r_ctrl[i])
          pos_next[i] = pos[i] - sat_step(pos[i] - MIN_P);
        else if (r_ctrl[i] && !l_ctrl[i])
          pos_next[i] = pos[i] + sat_step(MAX_P - pos[i]);
        tgt_next[i] = pos_next[i];
      end
    end
  end

  // Writes can never collide with the frame update because ready is low on frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pos[i] <= HOME_P;
        tgt[i] <= HOME_P;
      end
    end else begin
      err_q <= accept && bad_ch;
      if (!en || cnt == LAST_CNT)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (frame_tick) begin
          pos[i] <= pos_next[i];
          tgt[i] <= tgt_next[i];
        end else if (accept && !bad_ch && tgt_if.tgt_ch == CH_W'(i)) begin
          tgt[i] <= tgt_clamped;
        end
      end
    end
  end

  always_comb begin
    servo     = '0;
    at_target = '0;
    pos_flat  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      servo[i]                    = !rst && en && (cnt < pos[i]);
      at_target[i]                = (pos[i] == tgt[i]);
      pos_flat[i*CNT_W +: CNT_W]  = pos[i];
    end
  end

endmodule

// File: tb/tb_servo_array_ctrl.sv
// Scoreboard bench: per-frame pulse widths are queued when stimulus is applied
// and compared against widths measured on the servo pins.
module tb_servo_array_ctrl;
  localparam int CNT_W = 17;

  typedef struct {
    string tag;
    int    inst;
    int    ch;
    int    width;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic [3:0] l_a, r_a, mode_a, servo_a, at_a;
  logic [2:0] l_b, r_b, mode_b, servo_b, at_b;
  logic [4*CNT_W-1:0] pf_a;
  logic [3*CNT_W-1:0] pf_b;
  logic ft_a, ft_b;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;
  int waited;
  logic err_seen;
  int n;
  int seen_ft, seen_servo;

  servo_array_ctrl_if #(.CH_W(2), .CNT_W(CNT_W)) if_a ();
  servo_array_ctrl_if #(.CH_W(2), .CNT_W(CNT_W)) if_b ();

  servo_array_ctrl u_dut_a (
    .clk(clk), .rst(rst), .en(en),
    .l_ctrl(l_a), .r_ctrl(r_a), .mode(mode_a),
    .tgt_if(if_a.slave),
    .servo(servo_a), .frame_tick(ft_a), .at_target(at_a), .pos_flat(pf_a)
  );

  servo_array_ctrl #(.NUM_CH(3), .STEP(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en),
    .l_ctrl(l_b), .r_ctrl(r_b), .mode(mode_b),
    .tgt_if(if_b.slave),
    .servo(servo_b), .frame_tick(ft_b), .at_target(at_b), .pos_flat(pf_b)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int posA(input int ch);
    return int'(pf_a[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic int posB(input int ch);
    return int'(pf_b[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic applyStimulus(input int inst, input logic [3:0] l, input logic [3:0] r, input logic [3:0] m);
    if (inst == 0) begin
      l_a = l; r_a = r; mode_a = m;
    end else begin
      l_b = l[2:0]; r_b = r[2:0]; mode_b = m[2:0];
    end
  endtask

  task automatic expectWidth(input string tag, input int inst, input int ch, input int w);
    exp_t e;
    e.tag = $sformatf("%s_%s%0d", tag, (inst == 0) ? "a" : "b", ch);
    e.inst = inst;
    e.ch = ch;
    e.width = w;
    sb.push_back(e);
  endtask

  task automatic syncFrame();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ft_a && k < 300);
    checkOutput("sync_frame_tick", ft_a, 1'b1);
  endtask

  // Starts right after a frame_tick sample; measures the next full frame.
  task automatic runFrame();
    int wa[4];
    int wb[3];
    int fta, ftb;
    exp_t e;
    fta = 0; ftb = 0;
    for (int c = 0; c < 4; c++) wa[c] = 0;
    for (int c = 0; c < 3; c++) wb[c] = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) wa[c] += int'(servo_a[c]);
      for (int c = 0; c < 3; c++) wb[c] += int'(servo_b[c]);
      fta += int'(ft_a);
      ftb += int'(ft_b);
    end
    checkOutput("frame_tick_count_a", fta, 1);
    checkOutput("frame_tick_count_b", ftb, 1);
    checkOutput("frame_tick_last", ft_a, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, (e.inst == 0) ? wa[e.ch] : wb[e.ch], e.width);
    end
  endtask

  task automatic writeTgt(input int inst, input int ch, input int p, output int wt, output logic err);
    if (inst == 0) begin
      if_a.tgt_ch = 2'(ch); if_a.tgt_pos = CNT_W'(p); if_a.tgt_valid = 1'b1;
    end else begin
      if_b.tgt_ch = 2'(ch); if_b.tgt_pos = CNT_W'(p); if_b.tgt_valid = 1'b1;
    end
    wt = 0;
    while (!((inst == 0) ? if_a.tgt_ready : if_b.tgt_ready) && wt < 300) begin
      @(negedge clk);
      wt++;
    end
    if (wt >= 300) checkOutput("write_timeout", wt, 0);
    @(negedge clk);
    if_a.tgt_valid = 1'b0;
    if_b.tgt_valid = 1'b0;
    err = (inst == 0) ? if_a.tgt_err : if_b.tgt_err;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0;
    applyStimulus(0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1, 4'h0, 4'h0, 4'h0);
    if_a.tgt_valid = 1'b0; if_a.tgt_ch = '0; if_a.tgt_pos = '0;
    if_b.tgt_valid = 1'b0; if_b.tgt_ch = '0; if_b.tgt_pos = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_servo", servo_a, 4'h0);
    checkOutput("rst_frame_tick", ft_a, 1'b0);
    checkOutput("rst_ready", if_a.tgt_ready, 1'b0);
    checkOutput("rst_err", if_a.tgt_err, 1'b0);
    checkOutput("rst_at_target", at_a, 4'hF);
    for (int c = 0; c < 4; c++) checkOutput($sformatf("rst_pos%0d", c), posA(c), 15);

    rst = 1'b0; en = 1'b1;
    #1 checkOutput("start_servo", servo_a, 4'hF);

    // Idle frame at home position
    syncFrame();
    for (int c = 0; c < 4; c++) expectWidth("idle", 0, c, 15);
    for (int c = 0; c < 3; c++) expectWidth("idle", 1, c, 15);
    runFrame();
    checkOutput("idle_at_target", at_a, 4'hF);

    // Jog right to saturation, then both buttons, then left
    applyStimulus(0, 4'h0, 4'h1, 4'h0);
    for (int k = 1; k <= 10; k++) begin
      expectWidth("jog_up", 0, 0, (15 + k > 23) ? 23 : 15 + k);
      runFrame();
    end
    checkOutput("jog_tgt_follows", at_a, 4'hF);
    applyStimulus(0, 4'h1, 4'h1, 4'h0);
    for (int k = 0; k < 2; k++) begin
      expectWidth("jog_both", 0, 0, 23);
      runFrame();
    end
    applyStimulus(0, 4'h1, 4'h0, 4'h0);
    for (int w = 22; w >= 20; w--) begin
      expectWidth("jog_down", 0, 0, w);
      runFrame();
    end
    applyStimulus(0, 4'h0, 4'h0, 4'h0);

    applyStimulus(1, 4'h1, 4'h0, 4'h0);
    expectWidth("jog_step3", 1, 0, 12); runFrame();
    expectWidth("jog_step3", 1, 0, 9);  runFrame();
    expectWidth("jog_step3", 1, 0, 7);  runFrame();
    expectWidth("jog_step3", 1, 0, 7);  runFrame();
    applyStimulus(1, 4'h0, 4'h0, 4'h0);

    // Target slew on ch1, written at the frame boundary
    applyStimulus(0, 4'h0, 4'h0, 4'h2);
    checkOutput("ready_low_at_tick", if_a.tgt_ready, 1'b0);
    writeTgt(0, 1, 7, waited, err_seen);
    checkOutput("accept_after_tick", waited, 1);
    checkOutput("err_good_ch", err_seen, 1'b0);
    checkOutput("at_target1_left", at_a[1], 1'b0);
    checkOutput("pos1_before_tick", posA(1), 15);
    syncFrame();
    for (int w = 14; w >= 7; w--) begin
      expectWidth("slew", 0, 1, w);
      runFrame();
      checkOutput("slew_at_target1", at_a[1], (w == 7));
    end
    expectWidth("slew_hold", 0, 1, 7);
    runFrame();

    applyStimulus(1, 4'h0, 4'h0, 4'h2);
    writeTgt(1, 1, 7, waited, err_seen);
    syncFrame();
    expectWidth("slew_step3", 1, 1, 12); runFrame();
    expectWidth("slew_step3", 1, 1, 9);  runFrame();
    expectWidth("slew_step3", 1, 1, 7);  runFrame();
    expectWidth("slew_step3", 1, 1, 7);  runFrame();

    // Clamped targets on ch2
    applyStimulus(0, 4'h0, 4'h0, 4'h6);
    writeTgt(0, 2, 40, waited, err_seen);
    syncFrame();
    for (int w = 16; w <= 23; w++) begin
      expectWidth("clamp_hi", 0, 2, w);
      runFrame();
    end
    expectWidth("clamp_hi_hold", 0, 2, 23);
    runFrame();
    checkOutput("clamp_hi_at_target", at_a[2], 1'b1);
    writeTgt(0, 2, 0, waited, err_seen);
    syncFrame();
    for (int w = 22; w >= 7; w--) begin
      expectWidth("clamp_lo", 0, 2, w);
      runFrame();
    end
    expectWidth("clamp_lo_hold", 0, 2, 7);
    runFrame();
    checkOutput("clamp_lo_pos", posA(2), 7);

    // Nonexistent channel on the 3-channel instance
    writeTgt(1, 3, 20, waited, err_seen);
    checkOutput("bad_ch_err", err_seen, 1'b1);
    @(negedge clk);
    checkOutput("bad_ch_err_one_cycle", if_b.tgt_err, 1'b0);
    checkOutput("bad_ch_at_target", at_b, 3'b111);
    syncFrame();
    expectWidth("bad_ch_hold", 1, 0, 7);
    expectWidth("bad_ch_hold", 1, 1, 7);
    expectWidth("bad_ch_hold", 1, 2, 15);
    runFrame();
    checkOutput("bad_ch_at_target_after", at_b, 3'b111);
    checkOutput("bad_ch_pos2", posB(2), 15);

    // Reset mid-frame at cnt = 40
    repeat (41) @(negedge clk);
    checkOutput("pre_rst_pos0", posA(0), 20);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_servo", servo_a, 4'h0);
    checkOutput("mid_rst_ready", if_a.tgt_ready, 1'b0);
    for (int c = 0; c < 4; c++) checkOutput($sformatf("mid_rst_pos%0d", c), posA(c), 15);
    checkOutput("mid_rst_at_target", at_a, 4'hF);
    rst = 1'b0;
    #1 checkOutput("post_rst_servo", servo_a, 4'hF);
    n = 0;
    do begin @(negedge clk); n++; end while (!ft_a && n < 300);
    checkOutput("post_rst_frame_len", n, 99);
    for (int c = 0; c < 4; c++) expectWidth("post_rst", 0, c, 15);
    runFrame();

    // Enable dropped at cnt = 5, buttons ignored while disabled
    repeat (6) @(negedge clk);
    en = 1'b0;
    #1 checkOutput("en_low_servo", servo_a, 4'h0);
    applyStimulus(0, 4'h0, 4'h1, 4'h6);
    seen_ft = 0; seen_servo = 0;
    repeat (150) begin
      @(negedge clk);
      seen_ft += int'(ft_a);
      seen_servo += int'(|servo_a);
    end
    checkOutput("en_low_no_tick", seen_ft, 0);
    checkOutput("en_low_no_pulse", seen_servo, 0);
    checkOutput("en_low_pos_frozen", posA(0), 15);
    applyStimulus(0, 4'h0, 4'h0, 4'h6);
    en = 1'b1;
    #1 checkOutput("en_high_servo", servo_a, 4'hF);
    n = 0;
    do begin @(negedge clk); n++; end while (!ft_a && n < 300);
    checkOutput("en_high_frame_len", n, 99);
    for (int c = 0; c < 4; c++) expectWidth("en_resume", 0, c, 15);
    runFrame();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
